// File: rtl/reg_bank_arbiter.sv
// Three-requester round-robin write arbiter for a small register bank.
// Optional saturating stall counter on output stall_cnt, enabled by macro ARB_STALL_CNT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | outputs quiet; a pending request is arbitrated and latched
// S_WRITE | one-cycle commit of the latched write, grant to the winner
module reg_bank_arbiter #(
  parameter  int DATA_W = 2,
  parameter  int NREG   = 4,
  localparam int ADDR_W = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  output logic [2:0]        gnt,
  output logic [NREG-1:0]   chosen,
  output logic              w_en,
  output logic [DATA_W-1:0] w_data,
`ifdef ARB_STALL_CNT_EN
  output logic              busy,
  output logic [7:0]        stall_cnt
`else
  output logic              busy
`endif
);

  localparam logic [0:0]      S_IDLE   = 1'b0;
  localparam logic [0:0]      S_WRITE  = 1'b1;
  localparam logic [ADDR_W:0] NREG_LIM = (ADDR_W+1)'(NREG);

  logic [0:0]        r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_win;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic [1:0]        w_win;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [DATA_W-1:0] w_data_sel;
  logic              w_write;
  logic              w_addr_ok;

  // Round-robin search starting at r_ptr, wrapping 2 -> 0.
  always_comb begin
    logic [1:0] v_idx;
    logic       v_found;
    w_win   = r_ptr;
    v_idx   = r_ptr;
    v_found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (!v_found && req[v_idx]) begin
        w_win   = v_idx;
        v_found = 1'b1;
      end
      v_idx = (v_idx == 2'd2) ? 2'd0 : v_idx + 2'd1;
    end
  end

  always_comb begin
    w_addr_sel = addr0;
    w_data_sel = data0;
    case (w_win)
      2'd1: begin
        w_addr_sel = addr1;
        w_data_sel = data1;
      end
      2'd2: begin
        w_addr_sel = addr2;
        w_data_sel = data2;
      end
      default: begin
        w_addr_sel = addr0;
        w_data_sel = data0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_win   <= 2'd0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_win   <= w_win;
            r_addr  <= w_addr_sel;
            r_data  <= w_data_sel;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_state <= S_IDLE;
          r_ptr   <= (r_win == 2'd2) ? 2'd0 : r_win + 2'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so reset cannot glitch them.
  assign w_write   = (r_state == S_WRITE);
  assign w_addr_ok = ({1'b0, r_addr} < NREG_LIM);

  always_comb begin
    gnt = 3'b000;
    if (w_write) begin
      case (r_win)
        2'd0:    gnt = 3'b001;
        2'd1:    gnt = 3'b010;
        2'd2:    gnt = 3'b100;
        default: gnt = 3'b000;
      endcase
    end
  end

  always_comb begin
    chosen = '0;
    for (int k = 0; k < NREG; k++) begin
      chosen[k] = w_write && w_addr_ok && (r_addr == ADDR_W'(k));
    end
  end

  assign w_en   = w_write & w_addr_ok;
  assign w_data = w_write ? r_data : '0;
  assign busy   = w_write;

`ifdef ARB_STALL_CNT_EN
  logic [7:0] r_stall_cnt;
  logic       w_stall;

  // Any requester left waiting this cycle counts once.
  assign w_stall = |(req & ~gnt);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= 8'd0;
    end else if (w_stall && (r_stall_cnt != 8'hFF)) begin
      r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
